// File: rtl/stack_sequencer.sv
// Push/pop sequencer for a full-descending 16-bit stack in word memory.
// Define STACK_BOUNDS_CHECK_EN to abort pushes at STACK_LIMIT and pops at STACK_EMPTY.
module stack_sequencer #(
   parameter logic [15:0] STACK_EMPTY = 16'h8000,
   parameter logic [15:0] STACK_LIMIT = 16'h7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [15:0] push_data,
   input  logic [15:0] SPIn,
   output logic        SPWrite,
   output logic [15:0] SPNext,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] pop_data,
   output logic        busy,
   output logic        done,
   output logic        fault
);

`ifdef STACK_BOUNDS_CHECK_EN
   localparam logic BOUNDS_CHECK = 1'b1;
`else
   localparam logic BOUNDS_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      PUSH_WR,
      POP_RD,
      UPDATE,
      ABORT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] addr;
   logic [15:0] data;
   logic        is_pop;
   logic        take_push;
   logic        take_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= 16'h0000;
         data     <= 16'h0000;
         is_pop   <= 1'b0;
         pop_data <= 16'h0000;
      end else begin
         state <= state_next;
         if (take_push) begin
            addr   <= SPIn - 16'd2;
            data   <= push_data;
            is_pop <= 1'b0;
         end else if (take_pop) begin
            addr   <= SPIn;
            is_pop <= 1'b1;
         end
         if (state == POP_RD && mem_ready)
            pop_data <= mem_rdata;
      end
   end

   always_comb begin
      state_next = state;
      take_push  = 1'b0;
      take_pop   = 1'b0;
      SPWrite    = 1'b0;
      SPNext     = 16'h0000;
      mem_addr   = 16'h0000;
      mem_wdata  = 16'h0000;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (push) begin
               take_push = 1'b1;
               if (BOUNDS_CHECK && SPIn == STACK_LIMIT)
                  state_next = ABORT;
               else
                  state_next = PUSH_WR;
            end else if (pop) begin
               take_pop = 1'b1;
               if (BOUNDS_CHECK && SPIn == STACK_EMPTY)
                  state_next = ABORT;
               else
                  state_next = POP_RD;
            end
         end
         PUSH_WR: begin
            mem_we    = 1'b1;
            mem_addr  = addr;
            mem_wdata = data;
            if (mem_ready)
               state_next = UPDATE;
         end
         POP_RD: begin
            mem_re   = 1'b1;
            mem_addr = addr;
            if (mem_ready)
               state_next = UPDATE;
         end
         UPDATE: begin
            SPWrite    = 1'b1;
            SPNext     = is_pop ? addr + 16'd2 : addr;
            done       = 1'b1;
            state_next = IDLE;
         end
         ABORT: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef STACK_BOUNDS_CHECK_EN
   assign fault = (state == ABORT);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed self-checking bench for stack_sequencer.
module tb_stack_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        push;
   logic        pop;
   logic [15:0] push_data;
   logic [15:0] SPIn;
   logic        SPWrite;
   logic [15:0] SPNext;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [15:0] pop_data;
   logic        busy;
   logic        done;
   logic        fault;

   int n_cmp = 0;
   int n_err = 0;

   stack_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .SPIn      (SPIn),
      .SPWrite   (SPWrite),
      .SPNext    (SPNext),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .pop_data  (pop_data),
      .busy      (busy),
      .done      (done),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = 16'h0000;
      SPIn      = 16'h8000;
      mem_ready = 1'b1;
      mem_rdata = 16'h0000;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_spw", SPWrite, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_re", mem_re, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_spnext", SPNext, 16'h0000);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_wdata", mem_wdata, 16'h0000);
      chk("rst_popd", pop_data, 16'h0000);
      step();
      step();
      reset = 1'b0;
      step();

      // push BEEF at 8000, zero wait
      push_data = 16'hBEEF;
      push      = 1'b1;
      step();
      push = 1'b0;
      SPIn = 16'h1234;
      chk("push_we", mem_we, 1);
      chk("push_re", mem_re, 0);
      chk("push_addr", mem_addr, 16'h7FFE);
      chk("push_wdata", mem_wdata, 16'hBEEF);
      chk("push_busy", busy, 1);
      chk("push_spw0", SPWrite, 0);
      step();
      chk("push_spw", SPWrite, 1);
      chk("push_spnext", SPNext, 16'h7FFE);
      chk("push_done", done, 1);
      chk("push_we_upd", mem_we, 0);
      step();
      chk("push_idle", busy, 0);
      chk("push_done0", done, 0);
      chk("push_spw_idle", SPWrite, 0);

      // pop at 7FFE with two wait cycles
      SPIn      = 16'h7FFE;
      pop       = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      step();
      pop  = 1'b0;
      push = 1'b1;
      SPIn = 16'h4444;
      chk("pop_re1", mem_re, 1);
      chk("pop_we1", mem_we, 0);
      chk("pop_addr", mem_addr, 16'h7FFE);
      step();
      chk("pop_re2", mem_re, 1);
      step();
      chk("pop_re3", mem_re, 1);
      chk("pop_busy3", busy, 1);
      mem_ready = 1'b1;
      mem_rdata = 16'hBEEF;
      step();
      push      = 1'b0;
      mem_rdata = 16'h0000;
      chk("pop_re_upd", mem_re, 0);
      chk("pop_spw", SPWrite, 1);
      chk("pop_spnext", SPNext, 16'h8000);
      chk("pop_done", done, 1);
      chk("pop_data", pop_data, 16'hBEEF);
      step();
      chk("pop_idle", busy, 0);
      chk("pop_hold", pop_data, 16'hBEEF);
      step();
      chk("no_queue", busy, 0);

      // push and pop together: push wins
      SPIn      = 16'h8000;
      push_data = 16'h5A5A;
      push      = 1'b1;
      pop       = 1'b1;
      step();
      push = 1'b0;
      pop  = 1'b0;
      chk("both_we", mem_we, 1);
      chk("both_re", mem_re, 0);
      chk("both_addr", mem_addr, 16'h7FFE);
      step();
      chk("both_spnext", SPNext, 16'h7FFE);
      step();
      chk("both_idle", busy, 0);

      // wraparound: push at 0000, pop at FFFE
      SPIn      = 16'h0000;
      push_data = 16'h0101;
      push      = 1'b1;
      step();
      push = 1'b0;
      chk("wrap_push_addr", mem_addr, 16'hFFFE);
      step();
      chk("wrap_push_spn", SPNext, 16'hFFFE);
      step();
      SPIn      = 16'hFFFE;
      mem_rdata = 16'h0101;
      pop       = 1'b1;
      step();
      pop = 1'b0;
      chk("wrap_pop_addr", mem_addr, 16'hFFFE);
      step();
      chk("wrap_pop_spn", SPNext, 16'h0000);
      chk("wrap_pop_data", pop_data, 16'h0101);
      step();

`ifdef STACK_BOUNDS_CHECK_EN
      SPIn = 16'h8000;
      pop  = 1'b1;
      step();
      pop = 1'b0;
      chk("abort_pop_done", done, 1);
      chk("abort_pop_fault", fault, 1);
      chk("abort_pop_re", mem_re, 0);
      chk("abort_pop_spw", SPWrite, 0);
      step();
      chk("abort_pop_idle", busy, 0);
      chk("abort_pop_f0", fault, 0);
      SPIn = 16'h7F00;
      push = 1'b1;
      step();
      push = 1'b0;
      chk("abort_push_done", done, 1);
      chk("abort_push_fault", fault, 1);
      chk("abort_push_we", mem_we, 0);
      chk("abort_push_spw", SPWrite, 0);
      step();
      chk("abort_push_idle", busy, 0);
`else
      SPIn      = 16'h8000;
      mem_rdata = 16'h7777;
      pop       = 1'b1;
      step();
      pop = 1'b0;
      chk("empty_pop_re", mem_re, 1);
      chk("empty_pop_addr", mem_addr, 16'h8000);
      chk("empty_pop_fault", fault, 0);
      step();
      chk("empty_pop_spn", SPNext, 16'h8002);
      chk("empty_pop_fault2", fault, 0);
      step();
`endif

      // reset mid-POP_RD while memory stalls
      SPIn      = 16'h6000;
      mem_ready = 1'b0;
      pop       = 1'b1;
      step();
      pop = 1'b0;
      chk("mid_re", mem_re, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_re", mem_re, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr", mem_addr, 16'h0000);
      chk("mid_rst_popd", pop_data, 16'h0000);
      reset     = 1'b0;
      mem_ready = 1'b1;
      step();
      chk("mid_after_spw", SPWrite, 0);
      chk("mid_after_busy", busy, 0);

      SPIn      = 16'h4000;
      push_data = 16'h1234;
      push      = 1'b1;
      step();
      push = 1'b0;
      chk("post_we", mem_we, 1);
      chk("post_addr", mem_addr, 16'h3FFE);
      chk("post_wdata", mem_wdata, 16'h1234);
      step();
      chk("post_spw", SPWrite, 1);
      chk("post_spnext", SPNext, 16'h3FFE);
      step();
      chk("post_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
